// File: rtl/daq_event_builder_if.sv
// Channel-stream and DAQ-link signals of the event builder.
// The master modport is the event builder itself: it sinks the channel
// AXI4-streams and sources EventData towards the DAQ link. The slave
// modport is the surrounding logic (channel FPGAs and the DAQ link).
interface daq_event_builder_if #(
  parameter int N_CHAN = 5
);
  logic [N_CHAN-1:0]    s_axis_tvalid;
  logic [32*N_CHAN-1:0] s_axis_tdata;
  logic [N_CHAN-1:0]    s_axis_tlast;
  logic [N_CHAN-1:0]    s_axis_tready;
  logic                 daq_ready;
  logic                 daq_almost_full;
  logic                 daq_valid;
  logic                 daq_header;
  logic                 daq_trailer;
  logic [63:0]          daq_data;

  modport master (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, daq_ready, daq_almost_full,
    output s_axis_tready, daq_valid, daq_header, daq_trailer, daq_data
  );

  modport slave (
    output s_axis_tvalid, s_axis_tdata, s_axis_tlast, daq_ready, daq_almost_full,
    input  s_axis_tready, daq_valid, daq_header, daq_trailer, daq_data
  );
endinterface

// File: rtl/daq_event_builder.sv
// Event builder: waits for a packet on every enabled channel, then emits a
// header word, each enabled channel's packet (ascending channel order, two
// 32-bit beats per 64-bit word) and a trailer word on the DAQ link.
module daq_event_builder #(
  parameter int N_CHAN         = 5,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              axis_clk,
  input  logic              axis_clk_resetN,
  input  logic [N_CHAN-1:0] chan_en,
  daq_event_builder_if.master bus,
  output logic [23:0]       evt_num,
  output logic              busy
);

  localparam int CW = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, HDR, PAY, TRL} state_t;

  typedef struct packed {
    logic          found;
    logic [CW-1:0] idx;
  } pick_t;

  // Lowest set bit of mask strictly above position 'above' (-1 = lowest overall).
  function automatic pick_t next_chan(input logic [N_CHAN-1:0] mask, input int above);
    pick_t p;
    p = '0;
    for (int i = N_CHAN - 1; i >= 0; i--) begin
      if (mask[i] && i > above) begin
        p.found = 1'b1;
        p.idx   = CW'(i);
      end
    end
    return p;
  endfunction

  state_t            state;
  logic [N_CHAN-1:0] en_l;
  logic [N_CHAN-1:0] err_mask;
  logic [19:0]       word_cnt;
  logic [CW-1:0]     cur;
  logic [31:0]       hold_r;
  logic              hold_v;
  logic [TW-1:0]     idle_cnt;

  logic        go;
  logic        cur_valid;
  logic        cur_last;
  logic [31:0] cur_data;
  logic        accept;
  logic        timeout;
  logic        pay_emit;
  logic [63:0] pay_word;
  logic [19:0] cnt_inc;
  logic [23:0] evt_inc;
  pick_t       first;
  pick_t       nxt;

  assign go      = bus.daq_ready & ~bus.daq_almost_full;
  assign busy    = (state != IDLE);
  assign cnt_inc = (word_cnt == 20'hFFFFF) ? word_cnt : word_cnt + 20'd1;
  assign evt_inc = evt_num + 24'd1;

  // Current-channel selection, handshake and payload packing decisions.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    bus.s_axis_tready = '0;
    first     = next_chan(en_l, -1);
    nxt       = next_chan(en_l, int'(cur));
    cur_valid = bus.s_axis_tvalid[cur];
    cur_last  = bus.s_axis_tlast[cur];
    cur_data  = bus.s_axis_tdata[32*cur +: 32];
    if (state == PAY && go) bus.s_axis_tready[cur] = 1'b1;
    accept   = (state == PAY) && go && cur_valid;
    timeout  = (state == PAY) && go && !cur_valid && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
    pay_emit = (accept && (hold_v || cur_last)) || (timeout && hold_v);
    pay_word = accept ? (hold_v ? {cur_data, hold_r} : {32'h0, cur_data}) : {32'h0, hold_r};
  end

  // Event FSM with registered DAQ outputs.
  always_ff @(posedge axis_clk) begin
    // NOTE: reset is synchronous; a reset mid-event drops the partial hold word and emits no trailer.
    if (!axis_clk_resetN) begin
      state           <= IDLE;
      en_l            <= '0;
      err_mask        <= '0;
      word_cnt        <= '0;
      evt_num         <= '0;
      cur             <= '0;
      hold_r          <= '0;
      hold_v          <= 1'b0;
      idle_cnt        <= '0;
      bus.daq_valid   <= 1'b0;
      bus.daq_header  <= 1'b0;
      bus.daq_trailer <= 1'b0;
      bus.daq_data    <= '0;
    end else begin
      bus.daq_valid   <= 1'b0;
      bus.daq_header  <= 1'b0;
      bus.daq_trailer <= 1'b0;
      unique case (state)
        IDLE: begin
          if (chan_en != '0 && (bus.s_axis_tvalid & chan_en) == chan_en) begin
            en_l     <= chan_en;
            err_mask <= '0;
            word_cnt <= '0;
            state    <= HDR;
          end
        end
        HDR: begin
          if (go) begin
            bus.daq_valid  <= 1'b1;
            bus.daq_header <= 1'b1;
            bus.daq_data   <= {8'h00, evt_inc, 16'h0000, 16'(en_l)};
            word_cnt       <= 20'd1;
            cur            <= first.idx;
            hold_v         <= 1'b0;
            idle_cnt       <= '0;
            state          <= PAY;
          end
        end
        PAY: begin
          if (pay_emit) begin
            bus.daq_valid <= 1'b1;
            bus.daq_data  <= pay_word;
            word_cnt      <= cnt_inc;
          end
          if (accept) begin
            idle_cnt <= '0;
            hold_v   <= !hold_v && !cur_last;
            if (!hold_v) hold_r <= cur_data;
          end else if (timeout) begin
            err_mask[cur] <= 1'b1;
            hold_v        <= 1'b0;
            idle_cnt      <= '0;
          end else if (go) begin
            idle_cnt <= idle_cnt + 1'b1;
          end
          if ((accept && cur_last) || timeout) begin
            if (nxt.found) cur <= nxt.idx;
            else           state <= TRL;
          end
        end
        TRL: begin
          if (go) begin
            bus.daq_valid   <= 1'b1;
            bus.daq_trailer <= 1'b1;
            bus.daq_data    <= {evt_inc[7:0], 16'(err_mask), 20'h0, cnt_inc};
            evt_num         <= evt_inc;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_daq_event_builder.sv
// Self-checking bench for daq_event_builder: randomized channel traffic,
// expected DAQ word stream built from the event format rules.
module tb_daq_event_builder;
  localparam int N  = 3;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  chan_en;
  logic [23:0]   evt_num;
  logic          busy;

  daq_event_builder_if #(.N_CHAN(N)) bus ();

  daq_event_builder #(.N_CHAN(N), .TIMEOUT_CYCLES(TO)) dut (
    .axis_clk        (clk),
    .axis_clk_resetN (rst_n),
    .chan_en         (chan_en),
    .bus             (bus),
    .evt_num         (evt_num),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] pkt[N][$];   // words offered per channel (model input)
  logic [31:0] drv[N][$];   // words still to be handed to the DUT
  bit          cut[N];      // packet ends without tlast (abandoned by timeout)
  bit          noise[N];    // disabled channel wiggling tvalid
  logic [65:0] mon_q[$];    // observed {header, trailer, data}
  logic [65:0] exp_q[$];    // expected {header, trailer, data}
  logic [23:0] model_evt = '0;
  int          stall_after = -1;
  int          stall_len   = 0;
  bit          jitter      = 1'b0;
  logic        mon_go;

  // Output monitor: collects emitted words and checks link-level rules.
  always @(posedge clk) begin
    mon_go = bus.daq_ready & ~bus.daq_almost_full;
    #1;
    if (bus.daq_valid) begin
      checks++;
      if (!mon_go) begin
        errors++;
        $display("FAIL emit_without_go: daq_valid=1 after an edge with go=0, required 0");
      end
      checks++;
      if (bus.daq_header && bus.daq_trailer) begin
        errors++;
        $display("FAIL hdr_trl_both: header=1 trailer=1, required not both");
      end
      mon_q.push_back({bus.daq_header, bus.daq_trailer, bus.daq_data});
    end else if (bus.daq_header || bus.daq_trailer) begin
      checks++;
      errors++;
      $display("FAIL flag_without_valid: header=%0b trailer=%0b with valid=0, required 0",
               bus.daq_header, bus.daq_trailer);
    end
  end

  function automatic bit trl_seen();
    foreach (mon_q[i]) if (mon_q[i][64]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic clear_traffic();
    for (int c = 0; c < N; c++) begin
      pkt[c].delete();
      drv[c].delete();
      cut[c]   = 1'b0;
      noise[c] = 1'b0;
    end
  endtask

  task automatic load(input int c, input int n, input bit no_last);
    logic [31:0] w;
    pkt[c].delete();
    drv[c].delete();
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      pkt[c].push_back(w);
      drv[c].push_back(w);
    end
    cut[c] = no_last;
  endtask

  // Expected event: header, 32-bit beats paired low-first per channel, trailer.
  task automatic model_event(input logic [N-1:0] en);
    int          words;
    logic [15:0] err;
    logic [23:0] e;
    exp_q.delete();
    e     = model_evt + 24'd1;
    words = 1;
    err   = '0;
    exp_q.push_back({2'b10, 8'h00, e, 16'h0000, 16'(en)});
    for (int c = 0; c < N; c++) begin
      if (en[c]) begin
        if (cut[c]) err[c] = 1'b1;
        for (int i = 0; i < pkt[c].size(); i += 2) begin
          if (i + 1 < pkt[c].size()) exp_q.push_back({2'b00, pkt[c][i+1], pkt[c][i]});
          else                       exp_q.push_back({2'b00, 32'h0, pkt[c][i]});
          words++;
        end
      end
    end
    words++;
    exp_q.push_back({2'b01, e[7:0], err, 20'h0, 20'(words)});
    model_evt = e;
  endtask

  // Drive one cycle of channel traffic with random gaps.
  task automatic drive_inputs();
    for (int c = 0; c < N; c++) begin
      if (drv[c].size() > 0 && $urandom_range(3) != 0) begin
        bus.s_axis_tvalid[c]        = 1'b1;
        bus.s_axis_tdata[32*c +: 32] = drv[c][0];
        bus.s_axis_tlast[c]         = (drv[c].size() == 1) && !cut[c];
      end else if (noise[c]) begin
        bus.s_axis_tvalid[c]        = 1'($urandom_range(1));
        bus.s_axis_tdata[32*c +: 32] = $urandom;
        bus.s_axis_tlast[c]         = 1'($urandom_range(1));
      end else begin
        bus.s_axis_tvalid[c] = 1'b0;
        bus.s_axis_tlast[c]  = 1'b0;
      end
    end
  endtask

  // Run one event to its trailer and compare the whole word stream.
  task automatic run_event(input logic [N-1:0] en, input string name);
    int           cyc = 0;
    int           acc_n = 0;
    int           stall_left = 0;
    bit           stalled = 1'b0;
    logic         go;
    logic [N-1:0] acc;
    model_event(en);
    mon_q.delete();
    chan_en = en;
    while (!trl_seen() && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (stall_after >= 0 && !stalled && acc_n >= stall_after) begin
        stall_left = stall_len;
        stalled    = 1'b1;
      end
      bus.daq_almost_full = (stall_left > 0);
      if (stall_left > 0) stall_left--;
      bus.daq_ready = jitter ? ($urandom_range(7) != 0) : 1'b1;
      drive_inputs();
      #1;
      go  = bus.daq_ready & ~bus.daq_almost_full;
      acc = bus.s_axis_tvalid & bus.s_axis_tready;
      checks++;
      if ($countones(bus.s_axis_tready) > (go ? 1 : 0)) begin
        errors++;
        $display("FAIL %s tready_rule: tready=%b go=%0b, required at most one bit and none without go",
                 name, bus.s_axis_tready, go);
      end
      checks++;
      if ((bus.s_axis_tready & ~en) != '0) begin
        errors++;
        $display("FAIL %s tready_disabled: tready=%b en=%b, required no disabled bit", name,
                 bus.s_axis_tready, en);
      end
      @(posedge clk);
      for (int c = 0; c < N; c++) begin
        if (acc[c]) begin
          void'(drv[c].pop_front());
          acc_n++;
        end
      end
    end
    @(negedge clk);
    bus.s_axis_tvalid   = '0;
    bus.s_axis_tlast    = '0;
    bus.daq_almost_full = 1'b0;
    bus.daq_ready       = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (!trl_seen()) begin
      errors++;
      $display("FAIL %s no_trailer: %0d cycles without trailer, required a trailer", name, cyc);
    end
    checks++;
    if (mon_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s word_count: got %0d words, expected %0d", name, mon_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (i < mon_q.size()) begin
        checks++;
        if (mon_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL %s word[%0d]: got %h, expected %h", name, i, mon_q[i], exp_q[i]);
        end
      end
    end
    for (int c = 0; c < N; c++) begin
      checks++;
      if (drv[c].size() != 0) begin
        errors++;
        $display("FAIL %s consumed[%0d]: %0d words left, expected 0", name, c, drv[c].size());
      end
    end
    checks++;
    if (evt_num !== model_evt || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s evt_num: got %h busy=%0b, expected %h busy=0", name, evt_num, busy, model_evt);
    end
  endtask

  task automatic test_reset();
    rst_n               = 1'b0;
    chan_en             = '0;
    bus.s_axis_tvalid   = '0;
    bus.s_axis_tdata    = '0;
    bus.s_axis_tlast    = '0;
    bus.daq_ready       = 1'b1;
    bus.daq_almost_full = 1'b0;
    clear_traffic();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.daq_valid, bus.daq_header, bus.daq_trailer, busy} !== 4'b0 || bus.daq_data !== 64'h0 ||
        evt_num !== 24'h0 || bus.s_axis_tready !== '0) begin
      errors++;
      $display("FAIL reset_state: valid=%0b hdr=%0b trl=%0b busy=%0b data=%h evt=%h tready=%b, expected all 0",
               bus.daq_valid, bus.daq_header, bus.daq_trailer, busy, bus.daq_data, evt_num, bus.s_axis_tready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_two_channels();
    clear_traffic();
    load(0, 4, 1'b0);
    load(1, 3, 1'b0);
    run_event(3'b011, "two_chan");
    checks++;
    if (mon_q.size() < 1 || mon_q[0][63:0] !== 64'h00_000001_0000_0003) begin
      errors++;
      $display("FAIL two_chan header: got %h, expected 0000000100000003", mon_q.size() ? mon_q[0][63:0] : 64'h0);
    end
    checks++;
    if (mon_q.size() < 6 || mon_q[5][63:0] !== 64'h01_0000_00000_00006) begin
      errors++;
      $display("FAIL two_chan trailer: got %h, expected 0100000000000006", mon_q.size() > 5 ? mon_q[5][63:0] : 64'h0);
    end
  endtask

  task automatic test_disabled_noise();
    clear_traffic();
    load(0, 5, 1'b0);
    noise[1] = 1'b1;
    noise[2] = 1'b1;
    run_event(3'b001, "disabled_noise");
    checks++;
    if (mon_q.size() < 1 || mon_q[0][15:0] !== 16'h0001) begin
      errors++;
      $display("FAIL disabled_noise hdr_mask: got %h, expected 0001", mon_q.size() ? mon_q[0][15:0] : 16'h0);
    end
    clear_traffic();
  endtask

  task automatic test_stall();
    clear_traffic();
    load(0, 6, 1'b0);
    load(1, 5, 1'b0);
    stall_after = 3;
    stall_len   = 50;
    run_event(3'b011, "stall");
    stall_after = -1;
  endtask

  task automatic test_timeout();
    clear_traffic();
    load(0, 3, 1'b1);
    load(1, 4, 1'b0);
    run_event(3'b011, "timeout");
    checks++;
    if (mon_q.size() < 3 || mon_q[2][63:0] !== {32'h0, pkt[0][2]}) begin
      errors++;
      $display("FAIL timeout flush: got %h, expected %h", mon_q.size() > 2 ? mon_q[2][63:0] : 64'h0,
               {32'h0, pkt[0][2]});
    end
    checks++;
    if (mon_q.size() < 1 || mon_q[mon_q.size()-1][55:40] !== 16'h0001) begin
      errors++;
      $display("FAIL timeout err_mask: got %h, expected 0001",
               mon_q.size() ? mon_q[mon_q.size()-1][55:40] : 16'h0);
    end
    clear_traffic();
  endtask

  task automatic test_no_enable();
    int bad = 0;
    clear_traffic();
    mon_q.delete();
    chan_en = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      bus.s_axis_tvalid = '1;
      bus.s_axis_tlast  = '1;
      #1;
      checks++;
      if (busy !== 1'b0 || bus.s_axis_tready !== '0) begin
        errors++;
        bad++;
        if (bad < 4) $display("FAIL no_enable busy: busy=%0b tready=%b, expected 0", busy, bus.s_axis_tready);
      end
    end
    @(negedge clk);
    bus.s_axis_tvalid = '0;
    bus.s_axis_tlast  = '0;
    checks++;
    if (mon_q.size() != 0) begin
      errors++;
      $display("FAIL no_enable words: got %0d words, expected 0", mon_q.size());
    end
  endtask

  task automatic test_random();
    logic [N-1:0] en;
    jitter = 1'b1;
    for (int e = 0; e < 6; e++) begin
      clear_traffic();
      en = N'($urandom_range((1 << N) - 1, 1));
      for (int c = 0; c < N; c++) if (en[c]) load(c, $urandom_range(7, 1), 1'b0);
      run_event(en, "random");
    end
    jitter = 1'b0;
  endtask

  task automatic test_reset_mid();
    int           acc_n = 0;
    logic [N-1:0] acc;
    clear_traffic();
    load(0, 8, 1'b0);
    load(1, 3, 1'b0);
    chan_en = 3'b011;
    for (int cyc = 0; cyc < 300 && acc_n < 3; cyc++) begin
      @(negedge clk);
      drive_inputs();
      #1;
      acc = bus.s_axis_tvalid & bus.s_axis_tready;
      @(posedge clk);
      for (int c = 0; c < N; c++) if (acc[c]) begin
        void'(drv[c].pop_front());
        acc_n++;
      end
    end
    checks++;
    if (acc_n < 3) begin
      errors++;
      $display("FAIL reset_mid start: %0d accepts, expected 3", acc_n);
    end
    @(negedge clk);
    rst_n             = 1'b0;
    bus.s_axis_tvalid = '1;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.daq_valid, bus.daq_header, bus.daq_trailer, busy} !== 4'b0 || bus.daq_data !== 64'h0 ||
        evt_num !== 24'h0 || bus.s_axis_tready !== '0) begin
      errors++;
      $display("FAIL reset_mid state: valid=%0b hdr=%0b trl=%0b busy=%0b data=%h evt=%h tready=%b, expected all 0",
               bus.daq_valid, bus.daq_header, bus.daq_trailer, busy, bus.daq_data, evt_num, bus.s_axis_tready);
    end
    @(negedge clk);
    rst_n             = 1'b1;
    bus.s_axis_tvalid = '0;
    model_evt         = '0;
    clear_traffic();
    load(0, 3, 1'b0);
    run_event(3'b001, "after_reset");
  endtask

  task automatic test_wrap();
    clear_traffic();
    @(negedge clk);
    force dut.evt_num = 24'hFFFFFF;
    #1;
    release dut.evt_num;
    model_evt = 24'hFFFFFF;
    load(2, 2, 1'b0);
    run_event(3'b100, "wrap");
    checks++;
    if (mon_q.size() < 1 || mon_q[0][55:32] !== 24'h000000) begin
      errors++;
      $display("FAIL wrap hdr_evt: got %h, expected 000000", mon_q.size() ? mon_q[0][55:32] : 24'h0);
    end
  endtask

  initial begin
    test_reset();
    test_two_channels();
    test_disabled_noise();
    test_stall();
    test_timeout();
    test_no_enable();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
